// File: rtl/converter_pkg.sv
// converter_pkg: note boundary table, ASCII constants, note enum and letter/sharp lookup
package converter_pkg;
  typedef enum logic [3:0] {N_C, N_CS, N_D, N_DS, N_E, N_F, N_FS, N_G, N_GS, N_A, N_AS, N_B} note_t;
  localparam logic [15:0] BOUNDS [13] = '{16'd4067, 16'd4309, 16'd4565, 16'd4837, 16'd5124, 16'd5429,
                                          16'd5752, 16'd6094, 16'd6456, 16'd6840, 16'd7247, 16'd7678, 16'd8134};
  localparam logic [7:0] ASCII_DASH = 8'h2D;
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_A = 8'h41;
  localparam logic [2:0] LETTER_OFS [12] = '{3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd6, 3'd0, 3'd0, 3'd1};
  localparam logic [11:0] SHARP_MASK = 12'b0101_0100_1010;
  function automatic logic [7:0] note_letter(note_t n);
    return ASCII_A + {5'd0, LETTER_OFS[n]};
  endfunction
  function automatic logic note_sharp(note_t n);
    return SHARP_MASK[n];
  endfunction
endpackage

// File: rtl/note_lookup.sv
// note_lookup: combinational frequency (Hz) -> ASCII letter/octave, sharp flag, in_range
module note_lookup
  import converter_pkg::*;
(
  input  logic [15:0] frequency,
  output logic [7:0]  letter,
  output logic [7:0]  number,
  output logic        sharp,
  output logic        in_range
);
  logic [3:0] s;
  logic found;
  logic [23:0] scaled;
  note_t n;
  always_comb begin
    s = 4'd0;
    found = 1'b0;
    for (int i = 8; i >= 0; i--)
      if (({8'd0, frequency} << i) >= {8'd0, BOUNDS[0]}) begin
        s = 4'(i);
        found = 1'b1;
      end
    scaled = {8'd0, frequency} << s;
    n = N_C;
    for (int i = 1; i < 12; i++)
      if (scaled >= {8'd0, BOUNDS[i]}) n = note_t'(4'(i));
    in_range = found && (frequency < BOUNDS[12]);
    letter = in_range ? note_letter(n) : ASCII_DASH;
    number = in_range ? ASCII_ZERO + {4'd0, 4'd8 - s} : ASCII_DASH;
    sharp = in_range && note_sharp(n);
  end
endmodule

// File: rtl/frequency_converter.sv
// frequency_converter: frequency-to-note converter with combinational outputs and registered copies
module frequency_converter
  import converter_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] frequency,
  output logic [7:0]  letter,
  output logic [7:0]  number,
  output logic        sharp,
  output logic        in_range,
  output logic [7:0]  letter_q,
  output logic [7:0]  number_q,
  output logic        sharp_q,
  output logic        in_range_q
);
  note_lookup u_lookup (
    .frequency(frequency),
    .letter(letter),
    .number(number),
    .sharp(sharp),
    .in_range(in_range)
  );
  always_ff @(posedge clk) begin
    letter_q <= reset ? ASCII_DASH : letter;
    number_q <= reset ? ASCII_DASH : number;
    sharp_q <= reset ? 1'b0 : sharp;
    in_range_q <= reset ? 1'b0 : in_range;
  end
endmodule

// File: tb/tb_frequency_converter.sv
// tb_frequency_converter: directed scoreboard bench for frequency_converter
module tb_frequency_converter;
  typedef struct {
    logic [7:0] l;
    logic [7:0] n;
    logic s;
    logic r;
  } exp_t;
  logic clk = 1'b0;
  logic reset;
  logic [15:0] frequency;
  logic [7:0] letter, number, letter_q, number_q;
  logic sharp, in_range, sharp_q, in_range_q;
  exp_t sb_comb[$];
  exp_t sb_reg[$];
  int compared = 0;
  int mismatched = 0;
  frequency_converter dut (
    .clk(clk),
    .reset(reset),
    .frequency(frequency),
    .letter(letter),
    .number(number),
    .sharp(sharp),
    .in_range(in_range),
    .letter_q(letter_q),
    .number_q(number_q),
    .sharp_q(sharp_q),
    .in_range_q(in_range_q)
  );
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic comb(string tag, logic [15:0] f, logic [7:0] l, logic [7:0] n, logic s, logic r);
    exp_t e;
    @(negedge clk);
    frequency = f;
    sb_comb.push_back('{l, n, s, r});
    #1;
    e = sb_comb.pop_front();
    chk({tag, ".letter"}, letter, e.l);
    chk({tag, ".number"}, number, e.n);
    chk({tag, ".sharp"}, {7'd0, sharp}, {7'd0, e.s});
    chk({tag, ".in_range"}, {7'd0, in_range}, {7'd0, e.r});
  endtask
  task automatic regchk(string tag);
    exp_t e;
    e = sb_reg.pop_front();
    chk({tag, ".letter_q"}, letter_q, e.l);
    chk({tag, ".number_q"}, number_q, e.n);
    chk({tag, ".sharp_q"}, {7'd0, sharp_q}, {7'd0, e.s});
    chk({tag, ".in_range_q"}, {7'd0, in_range_q}, {7'd0, e.r});
  endtask
  initial begin
    reset = 1'b1;
    frequency = 16'd0;
    comb("f440", 16'd440, 8'h41, 8'h34, 1'b0, 1'b1);
    comb("f261", 16'd261, 8'h43, 8'h34, 1'b0, 1'b1);
    comb("f880", 16'd880, 8'h41, 8'h35, 1'b0, 1'b1);
    comb("f466", 16'd466, 8'h41, 8'h34, 1'b1, 1'b1);
    comb("f494", 16'd494, 8'h42, 8'h34, 1'b0, 1'b1);
    comb("f16", 16'd16, 8'h43, 8'h30, 1'b0, 1'b1);
    comb("f15", 16'd15, 8'h2D, 8'h2D, 1'b0, 1'b0);
    comb("f8133", 16'd8133, 8'h42, 8'h38, 1'b0, 1'b1);
    comb("f8134", 16'd8134, 8'h2D, 8'h2D, 1'b0, 1'b0);
    comb("f0", 16'd0, 8'h2D, 8'h2D, 1'b0, 1'b0);
    comb("f65535", 16'd65535, 8'h2D, 8'h2D, 1'b0, 1'b0);
    comb("f427", 16'd427, 8'h47, 8'h34, 1'b1, 1'b1);
    comb("f428", 16'd428, 8'h41, 8'h34, 1'b0, 1'b1);
    comb("f4067", 16'd4067, 8'h43, 8'h38, 1'b0, 1'b1);
    comb("f277", 16'd277, 8'h43, 8'h34, 1'b1, 1'b1);
    // reset held two edges with 440 applied
    @(negedge clk);
    reset = 1'b1;
    frequency = 16'd440;
    repeat (2) begin
      sb_reg.push_back('{8'h2D, 8'h2D, 1'b0, 1'b0});
      @(posedge clk);
      #1;
      regchk("rst");
      chk("rst.letter", letter, 8'h41);
      chk("rst.number", number, 8'h34);
    end
    @(negedge clk);
    reset = 1'b0;
    sb_reg.push_back('{8'h41, 8'h34, 1'b0, 1'b1});
    @(posedge clk);
    #1;
    regchk("post_rst");
    // latency: 261 then 880
    @(negedge clk);
    frequency = 16'd261;
    sb_reg.push_back('{8'h43, 8'h34, 1'b0, 1'b1});
    @(posedge clk);
    #1;
    regchk("lat261");
    @(negedge clk);
    frequency = 16'd880;
    sb_reg.push_back('{8'h43, 8'h34, 1'b0, 1'b1});
    #1;
    regchk("lat_hold");
    chk("lat.letter", letter, 8'h41);
    chk("lat.number", number, 8'h35);
    sb_reg.push_back('{8'h41, 8'h35, 1'b0, 1'b1});
    @(posedge clk);
    #1;
    regchk("lat880");
    // out-of-range registered
    @(negedge clk);
    frequency = 16'd8134;
    sb_reg.push_back('{8'h2D, 8'h2D, 1'b0, 1'b0});
    @(posedge clk);
    #1;
    regchk("oor_q");
    @(negedge clk);
    frequency = 16'd466;
    sb_reg.push_back('{8'h41, 8'h34, 1'b1, 1'b1});
    @(posedge clk);
    #1;
    regchk("sharp_q");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/frequency_converter.md
# frequency_converter

Combinational frequency-to-note converter with a registered output copy. Takes an integer frequency in Hz and returns the nearest equal-tempered note (A4 = 440 Hz) as ASCII letter and octave characters plus a sharp flag. It sits between the pitch-detection stage and the display/text driver. The zero-latency outputs drive same-cycle consumers; the registered copies feed clocked logic.

## Interface
- No parameters.
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high; clears the registered outputs only.
- frequency  input  16  detected frequency, unsigned integer Hz.
- letter  output  8  combinational ASCII note letter 'A'..'G' (0x41..0x47), or '-' (0x2D) when out of range.
- number  output  8  combinational ASCII octave digit '0'..'8' (0x30..0x38), or '-' (0x2D) when out of range.
- sharp  output  1  combinational; 1 when the note is a sharp (letter names the natural below).
- in_range  output  1  combinational; 1 when 16 ≤ frequency ≤ 8133.
- letter_q, number_q  output  8 each  registered copies of letter and number.
- sharp_q, in_range_q  output  1 each  registered copies of sharp and in_range.

## Operation
- Octave normalisation:
  - Find the minimal shift s in 0..8 such that (frequency << s) ≥ 4067, using 24-bit arithmetic.
  - Octave = 8 − s; scaled = frequency << s.
- Note selection:
  - Compare scaled against the ascending octave-8 lower-boundary table: 4067 C, 4309 C#, 4565 D, 4837 D#, 5124 E, 5429 F, 5752 F#, 6094 G, 6456 G#, 6840 A, 7247 A#, 7678 B, 8134 upper limit.
  - Note = the last boundary ≤ scaled.
  - Boundaries are ceil(f_note × 2^(−1/24)), i.e. geometric midpoints between semitones.
- Out of range: frequency < 16 (no shift reaches 4067), or frequency ≥ 8134. Outputs are then letter = number = 0x2D, sharp = 0, in_range = 0.
- Sharps: C#, D#, F#, G#, A# give letters C, D, F, G, A with sharp = 1. Naturals give sharp = 0.
- Number = 0x30 + octave.
- All combinational outputs depend only on the current frequency. There is no state on that path.

## Timing
- letter, number, sharp, in_range: zero-cycle combinational, valid within the same clock phase as frequency.
- *_q outputs: updated at each rising clk edge from the combinational values (1-cycle latency).
- While reset = 1 at a rising edge: letter_q = 0x2D, number_q = 0x2D, sharp_q = 0, in_range_q = 0.
- Reset has no effect on the combinational outputs.
- If reset deasserts, the next edge loads the current conversion.
- A frequency change that lands exactly on a clock edge is captured by *_q according to normal setup rules. There is no hold or debounce.

## Structure
- Package converter_pkg holds:
  - the 13-entry 16-bit boundary table;
  - the ASCII constants (dash, '0', 'A');
  - a 4-bit note enum (C..B, 0..11) and its letter/sharp lookup.
- One sub-module, note_lookup: purely combinational; frequency in, {letter, number, sharp, in_range} out.
- The top level instantiates note_lookup and adds the output register bank.

## Test plan
- 440 → 'A' (0x41), '4' (0x34), sharp 0. 261 → 'C' (0x43), '4'. 880 → 'A', '5' (0x35). All same-cycle, checked mid-cycle.
- 466 → 'A', '4', sharp 1 (A#4). 494 → 'B', '4', sharp 0.
- Boundaries:
  - 16 → 'C', '0', in_range 1.
  - 15 → 0x2D, 0x2D, in_range 0.
  - 8133 → 'B', '8'.
  - 8134 → 0x2D, 0x2D.
  - 0 and 65535 → 0x2D.
- Threshold edge: 427 vs 428 (427×16 = 6832 < 6840 → G#4; 428×16 = 6848 → A4).
- Reset: hold reset 2 cycles with frequency 440. Required: *_q = 0x2D/0x2D/0/0 while combinational outputs read 'A'/'4'. After deassert, *_q = 'A'/'4' one edge later.
- Latency: step frequency 261 → 880. Required: letter_q/number_q show 'C'/'4' until the next rising edge, then 'A'/'5'.
